stat_bank_sched: RTL and testbench

//  Scheduler for the double-banked statistics accumulator RAM (2x256x32, 9-bit addr, bit8 = bank).

---
 rtl/stat_pkg.sv | 9 +
 rtl/stat_ram_arb.sv | 34 +++
 rtl/stat_bank_sched.sv | 106 ++++++++++
 tb/tb_stat_bank_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// stat_pkg: shared widths, overflow-word addresses and scheduler state encodings
package stat_pkg;
  localparam int STAT_ADDR_W = 9;
  localparam int STAT_DATA_W = 32;
  localparam int STAT_BANK_WORDS = 256;
  localparam logic [7:0] OVF_ADDR_SEMI = 8'hF4;
  localparam logic [7:0] OVF_ADDR_FULL = 8'hFC;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWAP, S_SETTLE, S_RD, S_CAP, S_PUSH, S_CLR} state_t;
endpackage

// File: rtl/stat_ram_arb.sv
// stat_ram_arb: fixed-priority RAM port mux (engine over host) with host ack generation
module stat_ram_arb
  import stat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   eng_req,
  input  logic                   eng_we,
  input  logic [STAT_ADDR_W-1:0] eng_addr,
  input  logic [STAT_DATA_W-1:0] eng_data,
  input  logic                   host_cs,
  input  logic                   host_we,
  input  logic [STAT_ADDR_W-1:0] host_addr,
  input  logic [STAT_DATA_W-1:0] host_wdata,
  input  logic [STAT_DATA_W-1:0] ram_rdata,
  output logic [STAT_ADDR_W-1:0] ram_addr,
  output logic [STAT_DATA_W-1:0] ram_wdata,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic [STAT_DATA_W-1:0] host_rdata,
  output logic                   host_ack
);
  logic grant, rd_pend;
  always_comb begin
    grant = host_cs && !eng_req && !rd_pend;
    ram_cs = eng_req || grant;
    ram_we = eng_req ? eng_we : grant && host_we;
    ram_addr = eng_req ? eng_addr : grant ? host_addr : '0;
    ram_wdata = eng_req ? eng_data : grant ? host_wdata : '0;
    host_ack = rd_pend || (grant && host_we);
    host_rdata = rd_pend ? ram_rdata : '0;
  end
  always_ff @(posedge clk) rd_pend <= !rst && grant && !host_we;
endmodule

// File: rtl/stat_bank_sched.sv
// stat_bank_sched: periodic bank swap, read-then-clear dump of the idle bank, host RAM arbitration
module stat_bank_sched
  import stat_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int SETTLE = 4,
  parameter int DUMP_WORDS = STAT_BANK_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [PERIOD_W-1:0]    period_i,
  output logic                   ram_blk_sel_o,
  output logic [STAT_ADDR_W-1:0] ram_addr_o,
  output logic [STAT_DATA_W-1:0] ram_data_o,
  input  logic [STAT_DATA_W-1:0] ram_data_i,
  output logic                   ram_cs_o,
  output logic                   ram_we_o,
  input  logic [STAT_ADDR_W-1:0] host_addr_i,
  input  logic [STAT_DATA_W-1:0] host_data_i,
  input  logic                   host_cs_i,
  input  logic                   host_we_i,
  output logic [STAT_DATA_W-1:0] host_data_o,
  output logic                   host_ack_o,
  output logic [STAT_DATA_W-1:0] dump_data_o,
  output logic [7:0]             dump_idx_o,
  output logic                   dump_valid_o,
  input  logic                   dump_ready_i,
  output logic                   dump_last_o,
  output logic [15:0]            swap_cnt_o,
  output logic                   ovf_o
);
  localparam logic [7:0] LAST = 8'(DUMP_WORDS - 1);
  localparam logic [7:0] SET_END = 8'(SETTLE - 1);
  state_t state, nxt;
  logic [PERIOD_W-1:0] cnt, p;
  logic [7:0] idx, scnt;
  logic sel, pend, expire, dumping, eng_req, eng_we;
  assign p = period_i == '0 ? PERIOD_W'(1) : period_i;
  assign expire = cnt <= PERIOD_W'(1);
  assign ram_blk_sel_o = sel;
  assign dump_idx_o = idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= p;
      pend <= 1'b0;
      ovf_o <= 1'b0;
      sel <= 1'b0;
      swap_cnt_o <= '0;
      scnt <= '0;
      idx <= '0;
      dump_data_o <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == S_IDLE || state == S_SWAP || expire) ? p : cnt - PERIOD_W'(1);
      pend <= (state == S_IDLE || state == S_SWAP) ? 1'b0 : pend || expire;
      ovf_o <= ovf_o || (expire && dumping);
      sel <= sel ^ (state == S_SWAP);
      swap_cnt_o <= swap_cnt_o + 16'(state == S_SWAP);
      scnt <= state == S_SETTLE ? scnt + 8'd1 : 8'd0;
      idx <= state == S_SWAP ? 8'd0 : idx + 8'(state == S_CLR && idx != LAST);
      dump_data_o <= state == S_CAP ? ram_data_i : dump_data_o;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = en_i ? S_WAIT : S_IDLE;
      S_WAIT:   nxt = !en_i ? S_IDLE : (expire || pend) ? S_SWAP : S_WAIT;
      S_SWAP:   nxt = S_SETTLE;
      S_SETTLE: nxt = scnt == SET_END ? S_RD : S_SETTLE;
      S_RD:     nxt = S_CAP;
      S_CAP:    nxt = S_PUSH;
      S_PUSH:   nxt = dump_ready_i ? S_CLR : S_PUSH;
      S_CLR:    nxt = idx == LAST ? S_WAIT : S_RD;
      default:  nxt = S_IDLE;
    endcase
  end
  always_comb begin
    eng_req = state == S_RD || state == S_CLR;
    eng_we = state == S_CLR;
    dumping = state inside {S_SETTLE, S_RD, S_CAP, S_PUSH, S_CLR};
    dump_valid_o = state == S_PUSH;
    dump_last_o = dump_valid_o && idx == LAST;
  end
  stat_ram_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .eng_req   (eng_req),
    .eng_we    (eng_we),
    .eng_addr  ({~sel, idx}),
    .eng_data  ('0),
    .host_cs   (host_cs_i),
    .host_we   (host_we_i),
    .host_addr (host_addr_i),
    .host_wdata(host_data_i),
    .ram_rdata (ram_data_i),
    .ram_addr  (ram_addr_o),
    .ram_wdata (ram_data_o),
    .ram_cs    (ram_cs_o),
    .ram_we    (ram_we_o),
    .host_rdata(host_data_o),
    .host_ack  (host_ack_o)
  );
endmodule

// File: tb/tb_stat_bank_sched.sv
// tb_stat_bank_sched: scoreboard bench with behavioural 512x32 RAM for stat_bank_sched
module tb_stat_bank_sched;
  typedef struct {logic [7:0] idx; logic [31:0] data;} exp_t;
  logic clk = 0, rst = 1, en_i = 0, preload = 1;
  logic [23:0] period_i = 24'd100;
  logic ram_blk_sel_o, ram_cs_o, ram_we_o, host_ack_o, dump_valid_o, dump_last_o, ovf_o;
  logic [8:0] ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i = 0, host_data_o, dump_data_o;
  logic [8:0] host_addr_i = 0;
  logic [31:0] host_data_i = 0;
  logic host_cs_i = 0, host_we_i = 0, dump_ready_i = 0;
  logic [7:0] dump_idx_o;
  logic [15:0] swap_cnt_o;
  logic [31:0] mem [512];
  exp_t sb[$];
  logic [31:0] hq[$];
  int tests = 0, fails = 0, mode = 1, n = 0, last_n = 0;
  logic psel = 0, stall_prev = 0, host_run = 0;
  logic [39:0] stall_val = 0;
  stat_bank_sched dut (
    .clk(clk), .rst(rst), .en_i(en_i), .period_i(period_i),
    .ram_blk_sel_o(ram_blk_sel_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i), .host_cs_i(host_cs_i),
    .host_we_i(host_we_i), .host_data_o(host_data_o), .host_ack_o(host_ack_o),
    .dump_data_o(dump_data_o), .dump_idx_o(dump_idx_o), .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i), .dump_last_o(dump_last_o), .swap_cnt_o(swap_cnt_o),
    .ovf_o(ovf_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (preload)
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 32'(i + 1);
        mem[256 + i] <= 32'h1000 + 32'(i);
      end
    else if (ram_cs_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
      else ram_data_i <= mem[ram_addr_o];
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    dump_ready_i = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    int m;
    exp_t e;
    m = (ram_blk_sel_o != psel) ? 0 : n + 1;
    n <= m;
    psel <= ram_blk_sel_o;
    if (!rst) begin
      if (stall_prev) chk("hold", {dump_valid_o, dump_idx_o, dump_data_o}, {1'b1, stall_val});
      if (dump_valid_o && dump_ready_i) begin
        if (sb.size() == 0) chk("dump_extra", {dump_idx_o, dump_data_o}, 0);
        else begin
          e = sb.pop_front();
          chk("dump_idx", dump_idx_o, e.idx);
          chk("dump_data", dump_data_o, e.data);
          chk("dump_last", dump_last_o, e.idx == 8'd255);
        end
        if (dump_last_o) last_n <= m;
      end
      if (host_ack_o) begin
        if (hq.size() == 0) chk("host_extra", host_data_o, 0);
        else chk("host_rd", host_data_o, hq.pop_front());
      end
    end
    stall_prev <= !rst && dump_valid_o && !dump_ready_i;
    stall_val <= {dump_idx_o, dump_data_o};
  end
  task automatic push_bank(input bit b, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back('{8'(i), b ? 32'h1000 + 32'(i) : 32'(i + 1)});
  endtask
  task automatic reset_dut();
    rst = 1;
    en_i = 0;
    preload = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    preload = 0;
    sb.delete();
    hq.delete();
  endtask
  task automatic chk_zero(input string pfx);
    chk({pfx, "_ram"}, {ram_addr_o, ram_data_o, ram_cs_o, ram_we_o}, 0);
    chk({pfx, "_dump"}, {dump_data_o, dump_idx_o, dump_valid_o, dump_last_o}, 0);
    chk({pfx, "_misc"}, {ram_blk_sel_o, host_data_o, host_ack_o, swap_cnt_o, ovf_o}, 0);
  endtask
  task automatic wait_sel(input string tag, input logic v, input int lim, output int w);
    w = 0;
    while (ram_blk_sel_o !== v && w < lim) begin
      @(negedge clk);
      w++;
    end
    chk(tag, ram_blk_sel_o, v);
  endtask
  task automatic wait_idx(input string tag, input logic [7:0] i, input int lim);
    int b = 0;
    while (!(dump_valid_o && dump_idx_o == i) && b < lim) begin
      @(negedge clk);
      b++;
    end
    chk(tag, b < lim, 1);
  endtask
  task automatic wait_drain(input string tag, input int lim);
    int b = 0;
    while (sb.size() != 0 && b < lim) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask
  function automatic int bank_bad(input bit b, input int lo);
    int bad = 0;
    for (int i = lo; i < 256; i++)
      if (mem[b ? 256 + i : i] !== (b ? 32'h1000 + 32'(i) : 32'(i + 1))) bad++;
    return bad;
  endfunction
  function automatic int bank_nonzero(input bit b);
    int nz = 0;
    for (int i = 0; i < 256; i++) if (mem[b ? 256 + i : i] !== 0) nz++;
    return nz;
  endfunction
  initial begin
    int w, b, host_n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    // dump with en dropped mid-way: full bank, then idle with frozen swap count
    period_i = 24'd100;
    mode = 1;
    reset_dut();
    push_bank(0, 256);
    en_i = 1;
    wait_sel("t1_sel", 1, 200, w);
    chk("t1_swap_time", w >= 90 && w <= 110, 1);
    chk("t1_swap_cnt", swap_cnt_o, 1);
    wait_idx("t1_idx100", 8'd100, 600);
    @(posedge clk);
    #1;
    en_i = 0;
    wait_drain("t1_drain", 1000);
    chk("t1_time", last_n, 1026);
    repeat (300) @(negedge clk);
    chk("t6_swap_frozen", swap_cnt_o, 1);
    chk("t6_sel", ram_blk_sel_o, 1);
    chk("t6_idle", {ram_cs_o, dump_valid_o}, 0);
    chk("t1_cleared", bank_nonzero(0), 0);
    chk("t1_other_bank", bank_bad(1, 0), 0);
    // random backpressure
    mode = 2;
    reset_dut();
    push_bank(0, 256);
    en_i = 1;
    wait_sel("t2_sel", 1, 200, w);
    wait_idx("t2_idx100", 8'd100, 2000);
    @(posedge clk);
    #1;
    en_i = 0;
    wait_drain("t2_drain", 3000);
    repeat (5) @(negedge clk);
    chk("t2_swap_cnt", swap_cnt_o, 1);
    chk("t2_cleared", bank_nonzero(0), 0);
    // continuous host reads during dump
    mode = 1;
    reset_dut();
    push_bank(0, 256);
    en_i = 1;
    wait_sel("t3_sel", 1, 200, w);
    host_n = 0;
    host_run = 1;
    fork
      begin
        while (host_run) begin
          host_addr_i = 9'h105;
          host_we_i = 0;
          host_cs_i = 1;
          hq.push_back(32'h1005);
          b = 0;
          do begin
            @(negedge clk);
            b++;
          end while (!host_ack_o && b < 20);
          chk("t3_host_ack", b < 20, 1);
          host_n++;
          @(posedge clk);
          #1;
        end
        host_cs_i = 0;
      end
      begin
        wait_idx("t3_idx100", 8'd100, 600);
        @(posedge clk);
        #1;
        en_i = 0;
        wait_drain("t3_drain", 1000);
        host_run = 0;
      end
    join
    repeat (3) @(negedge clk);
    chk("t3_time", last_n, 1026);
    chk("t3_host_count", host_n >= 200, 1);
    chk("t3_hq_empty", hq.size(), 0);
    // overflow with long stall, exactly one deferred swap
    period_i = 24'd50;
    mode = 0;
    reset_dut();
    push_bank(0, 256);
    push_bank(1, 256);
    en_i = 1;
    wait_sel("t4_sel", 1, 100, w);
    wait_idx("t4_first", 8'd0, 20);
    repeat (200) @(negedge clk);
    chk("t4_ovf_stall", ovf_o, 1);
    chk("t4_cnt_stall", swap_cnt_o, 1);
    mode = 1;
    b = 0;
    while (!(dump_valid_o && dump_last_o && dump_ready_i) && b < 1500) begin
      @(negedge clk);
      b++;
    end
    chk("t4_last", b < 1500, 1);
    repeat (3) @(negedge clk);
    chk("t4_cnt_before", swap_cnt_o, 1);
    @(negedge clk);
    chk("t4_cnt_deferred", swap_cnt_o, 2);
    chk("t4_sel_back", ram_blk_sel_o, 0);
    repeat (200) @(negedge clk);
    chk("t4_cnt_single", swap_cnt_o, 2);
    chk("t4_ovf_sticky", ovf_o, 1);
    // reset mid-dump
    period_i = 24'd100;
    reset_dut();
    push_bank(0, 18);
    en_i = 1;
    wait_sel("t5_sel", 1, 200, w);
    wait_idx("t5_idx17", 8'd17, 200);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("t5");
    chk("t5_sb", sb.size(), 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (20) @(negedge clk);
    chk("t5_untouched", bank_bad(0, 18), 0);
    chk("t5_idle_sel", ram_blk_sel_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
